// File: rtl/minimig_ac_pkg.sv
// Shared definitions for the Minimig Zorro autoconfig sequencer.
// Holds the autoconfig register byte offsets, the chain device codes, the
// sequencer FSM state type and a helper that finds the next present board.
package minimig_ac_pkg;

  // Byte offsets inside the $E80000 autoconfig window.
  localparam logic [8:0] OFF_Z3_BASE = 9'h044;  // ZIII/ETH base, A31:16
  localparam logic [8:0] OFF_BASE_HI = 9'h048;  // ZII base A23:20, configures
  localparam logic [8:0] OFF_BASE_LO = 9'h04A;  // ZII base A19:16, pending only
  localparam logic [8:0] OFF_SHUTUP  = 9'h04C;  // shut-up, any device

  // Chain device codes, also used as the autoconfig ROM page.
  localparam logic [2:0] DEV_ZII  = 3'd0;
  localparam logic [2:0] DEV_Z3A  = 3'd1;
  localparam logic [2:0] DEV_Z3B  = 3'd2;
  localparam logic [2:0] DEV_ETH  = 3'd3;
  localparam logic [2:0] DEV_NONE = 3'd7;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_ACTIVE,
    ST_DONE
  } ac_state_e;

  // Lowest present board index that is >= from, or DEV_NONE if there is none.
  // Scanning downwards lets the lowest matching index win.
  function automatic logic [2:0] first_present(input logic [3:0] present,
                                               input logic [2:0] from);
    first_present = DEV_NONE;
    for (int i = 3; i >= 0; i--) begin
      if (present[i] && (3'(i) >= from)) first_present = 3'(i);
    end
  endfunction

endpackage

// File: rtl/minimig_ac_base_decode.sv
// Base-address comparators and registered per-board hit strobes.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   cpu_addr          CPU address [31:16]
//   zii_base          ZII base A23:16; zii_size selects 2/4/8 MB compare width
//   z3a_base          ZIII RAM A base A31:16 (16 MB, only A31:24 compared)
//   z3b_base, z3b_4m  ZIII RAM B base A31:16 and 4 MB/2 MB size select
//   eth_base          Ethernet base A31:16 (64 KB)
//   board_configured  per-board configured flags
//   board_shutup      per-board shut-up flags
//   board_hit         registered hit, one clk after cpu_addr
module minimig_ac_base_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  zii_base,
  input  logic [1:0]  zii_size,
  input  logic [15:0] z3a_base,
  input  logic [15:0] z3b_base,
  input  logic        z3b_4m,
  input  logic [15:0] eth_base,
  input  logic [3:0]  board_configured,
  input  logic [3:0]  board_shutup,
  output logic [3:0]  board_hit
);

  logic [3:0]  board_hit_d, board_hit_q;
  logic [7:0]  zii_mask;
  logic [15:0] z3b_mask;
  logic [3:0]  match;

  // Each comparator XORs address against base and masks to the bits that
  // define the board's window; a zero result means the address is inside.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    zii_mask = 8'h80;  // 8 MB: A23 only
    case (zii_size)
      2'b01:   zii_mask = 8'hE0;  // 2 MB: A23:21
      2'b10:   zii_mask = 8'hC0;  // 4 MB: A23:22
      default: zii_mask = 8'h80;
    endcase
    z3b_mask = z3b_4m ? 16'hFFC0 : 16'hFFE0;

    match[0] = (cpu_addr[15:8] == 8'h00) &&
               (((cpu_addr[7:0] ^ zii_base) & zii_mask) == 8'h00);
    match[1] = ((cpu_addr ^ z3a_base) & 16'hFF00) == 16'h0000;
    match[2] = ((cpu_addr ^ z3b_base) & z3b_mask) == 16'h0000;
    match[3] = cpu_addr == eth_base;

    board_hit_d = match & board_configured & ~board_shutup;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample the same pre-edge values.
    if (reset) board_hit_q <= '0;
    else       board_hit_q <= board_hit_d;
  end

  assign board_hit = board_hit_q;

endmodule

// File: rtl/minimig_autoconfig_sequencer.sv
// Zorro autoconfig chain sequencer for Minimig.
// Walks the present boards (ZII RAM, ZIII RAM A, ZIII RAM B, Ethernet) in
// fixed order, accepts Kickstart's base-address and shut-up writes in the
// autoconfig window, and owns the resulting bases for address decode.
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   clk7_en                    7 MHz qualifier for window writes
//   address_in, data_in        CPU address [8:1] and write data
//   hwr, lwr, sel              byte write strobes, window select
//   board_enable, zii_size,    board presence and sizes (presence latched
//   z3b_4m                     in INIT)
//   cpu_addr                   CPU address [31:16] for decode
//   ac_device                  current chain device / ROM page (7 = none)
//   board_configured,          per-board configured / shut-up flags
//   board_shutup
//   board_hit                  registered per-board address hit
//   autoconfig_done            chain exhausted
module minimig_autoconfig_sequencer
  import minimig_ac_pkg::*;
#(
  parameter bit ETH_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic [7:0]  address_in,
  input  logic [15:0] data_in,
  input  logic        hwr,
  input  logic        lwr,
  input  logic        sel,
  input  logic [3:0]  board_enable,
  input  logic [1:0]  zii_size,
  input  logic        z3b_4m,
  input  logic [15:0] cpu_addr,
  output logic [2:0]  ac_device,
  output logic [3:0]  board_configured,
  output logic [3:0]  board_shutup,
  output logic [3:0]  board_hit,
  output logic        autoconfig_done
);

  ac_state_e   state_d, state_q;
  logic [2:0]  ac_device_d, ac_device_q;
  logic [3:0]  present_d, present_q;
  logic [3:0]  configured_d, configured_q;
  logic [3:0]  shutup_d, shutup_q;
  logic        done_d, done_q;
  logic [3:0]  pending_d, pending_q;
  logic [7:0]  zii_base_d, zii_base_q;
  logic [15:0] z3a_base_d, z3a_base_q;
  logic [15:0] z3b_base_d, z3b_base_q;
  logic [15:0] eth_base_d, eth_base_q;

  logic        wr;
  logic        advance;
  logic [8:0]  offset;
  logic [1:0]  idx;

  assign wr     = clk7_en && sel && (hwr || lwr);
  assign offset = {address_in, 1'b0};
  assign idx    = ac_device_q[1:0];

  always_comb begin
    state_d      = state_q;
    ac_device_d  = ac_device_q;
    present_d    = present_q;
    configured_d = configured_q;
    shutup_d     = shutup_q;
    done_d       = done_q;
    pending_d    = pending_q;
    zii_base_d   = zii_base_q;
    z3a_base_d   = z3a_base_q;
    z3b_base_d   = z3b_base_q;
    eth_base_d   = eth_base_q;
    advance      = 1'b0;

    case (state_q)
      ST_INIT: begin
        // A ZII board with size 00 has no memory to map, so it is absent.
        present_d   = {board_enable[3] & ETH_EN, board_enable[2:1],
                       board_enable[0] & (|zii_size)};
        ac_device_d = first_present(present_d, DEV_ZII);
        if (ac_device_d == DEV_NONE) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        if (wr) begin
          if (offset == OFF_SHUTUP) begin
            shutup_d[idx] = 1'b1;
            advance       = 1'b1;
          end else if (ac_device_q == DEV_ZII) begin
            // The low nibble arrives first and only takes effect together
            // with the high nibble write, which is the configuring one.
            if (offset == OFF_BASE_LO) begin
              pending_d = data_in[15:12];
            end else if (offset == OFF_BASE_HI) begin
              zii_base_d        = {data_in[15:12], pending_q};
              configured_d[idx] = 1'b1;
              advance           = 1'b1;
            end
          end else if (offset == OFF_Z3_BASE) begin
            case (ac_device_q)
              DEV_Z3A: begin
                if (hwr) z3a_base_d[15:8] = data_in[15:8];
                if (lwr) z3a_base_d[7:0]  = data_in[7:0];
              end
              DEV_Z3B: begin
                if (hwr) z3b_base_d[15:8] = data_in[15:8];
                if (lwr) z3b_base_d[7:0]  = data_in[7:0];
              end
              default: begin
                if (hwr) eth_base_d[15:8] = data_in[15:8];
                if (lwr) eth_base_d[7:0]  = data_in[7:0];
              end
            endcase
            configured_d[idx] = 1'b1;
            advance           = 1'b1;
          end
        end

        if (advance) begin
          ac_device_d = first_present(present_q, ac_device_q + 3'd1);
          if (ac_device_d == DEV_NONE) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        // ST_DONE holds until reset.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      ac_device_q  <= DEV_NONE;
      present_q    <= '0;
      configured_q <= '0;
      shutup_q     <= '0;
      done_q       <= 1'b0;
      pending_q    <= '0;
      zii_base_q   <= '0;
      z3a_base_q   <= '0;
      z3b_base_q   <= '0;
      eth_base_q   <= '0;
    end else begin
      state_q      <= state_d;
      ac_device_q  <= ac_device_d;
      present_q    <= present_d;
      configured_q <= configured_d;
      shutup_q     <= shutup_d;
      done_q       <= done_d;
      pending_q    <= pending_d;
      zii_base_q   <= zii_base_d;
      z3a_base_q   <= z3a_base_d;
      z3b_base_q   <= z3b_base_d;
      eth_base_q   <= eth_base_d;
    end
  end

  minimig_ac_base_decode u_decode (
    .clk              (clk),
    .reset            (reset),
    .cpu_addr         (cpu_addr),
    .zii_base         (zii_base_q),
    .zii_size         (zii_size),
    .z3a_base         (z3a_base_q),
    .z3b_base         (z3b_base_q),
    .z3b_4m           (z3b_4m),
    .eth_base         (eth_base_q),
    .board_configured (configured_q),
    .board_shutup     (shutup_q),
    .board_hit        (board_hit)
  );

  assign ac_device        = ac_device_q;
  assign board_configured = configured_q;
  assign board_shutup     = shutup_q;
  assign autoconfig_done  = done_q;

endmodule

// File: tb/tb_minimig_autoconfig_sequencer.sv
// Self-checking bench for minimig_autoconfig_sequencer: a table of
// per-cycle vectors with expected outputs queued on drive and compared after
// the clock edge, plus a hand-written decode-latency sequence.
module tb_minimig_autoconfig_sequencer;

  logic        clk;
  logic        reset;
  logic        clk7_en;
  logic [7:0]  address_in;
  logic [15:0] data_in;
  logic        hwr, lwr, sel;
  logic [3:0]  board_enable;
  logic [1:0]  zii_size;
  logic        z3b_4m;
  logic [15:0] cpu_addr;
  logic [2:0]  ac_device;
  logic [3:0]  board_configured, board_shutup, board_hit;
  logic        autoconfig_done;

  minimig_autoconfig_sequencer #(.ETH_EN(1'b1)) dut (
    .clk              (clk),
    .reset            (reset),
    .clk7_en          (clk7_en),
    .address_in       (address_in),
    .data_in          (data_in),
    .hwr              (hwr),
    .lwr              (lwr),
    .sel              (sel),
    .board_enable     (board_enable),
    .zii_size         (zii_size),
    .z3b_4m           (z3b_4m),
    .cpu_addr         (cpu_addr),
    .ac_device        (ac_device),
    .board_configured (board_configured),
    .board_shutup     (board_shutup),
    .board_hit        (board_hit),
    .autoconfig_done  (autoconfig_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;    // run a reset phase before this vector
    logic [3:0]  en;
    logic [1:0]  zsz;
    logic        z4;
    logic [8:0]  off;
    logic [15:0] data;
    logic        hw, lw, sl, c7;
    logic [15:0] cpu;
    logic [2:0]  e_dev;
    logic [3:0]  e_cfg, e_shut;
    logic        e_done;
    logic [3:0]  e_hit;
  } vec_t;

  typedef struct {
    string       name;
    logic [2:0]  dev;
    logic [3:0]  cfg, shut;
    logic        done;
    logic [3:0]  hit;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic add(input bit rst, input logic [3:0] en, input logic [1:0] zsz,
                     input logic z4, input logic [8:0] off, input logic [15:0] data,
                     input logic hw, input logic lw, input logic sl, input logic c7,
                     input logic [15:0] cpu, input logic [2:0] e_dev,
                     input logic [3:0] e_cfg, input logic [3:0] e_shut,
                     input logic e_done, input logic [3:0] e_hit);
    vec_t t;
    t.rst = rst; t.en = en; t.zsz = zsz; t.z4 = z4; t.off = off; t.data = data;
    t.hw = hw; t.lw = lw; t.sl = sl; t.c7 = c7; t.cpu = cpu;
    t.e_dev = e_dev; t.e_cfg = e_cfg; t.e_shut = e_shut; t.e_done = e_done;
    t.e_hit = e_hit;
    vecs.push_back(t);
  endtask

  // Idle cycle: no window access, only a CPU address for decode.
  task automatic idle(input logic [3:0] en, input logic [1:0] zsz, input logic z4,
                      input logic [15:0] cpu, input logic [2:0] e_dev,
                      input logic [3:0] e_cfg, input logic [3:0] e_shut,
                      input logic e_done, input logic [3:0] e_hit);
    add(1'b0, en, zsz, z4, 9'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, cpu,
        e_dev, e_cfg, e_shut, e_done, e_hit);
  endtask

  task automatic drive(input vec_t t);
    board_enable = t.en;
    zii_size     = t.zsz;
    z3b_4m       = t.z4;
    address_in   = t.off[8:1];
    data_in      = t.data;
    hwr          = t.hw;
    lwr          = t.lw;
    sel          = t.sl;
    clk7_en      = t.c7;
    cpu_addr     = t.cpu;
  endtask

  task automatic compare_next();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = exp_q.pop_front();
      check({e.name, "_dev"},  16'(ac_device),        16'(e.dev));
      check({e.name, "_cfg"},  16'(board_configured), 16'(e.cfg));
      check({e.name, "_shut"}, 16'(board_shutup),     16'(e.shut));
      check({e.name, "_done"}, 16'(autoconfig_done),  16'(e.done));
      check({e.name, "_hit"},  16'(board_hit),        16'(e.hit));
    end
  endtask

  // Two reset cycles with a shut-up write held on the bus: reset must win.
  task automatic reset_phase(input vec_t t, input int i);
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      reset        = 1'b1;
      board_enable = t.en;
      zii_size     = t.zsz;
      z3b_4m       = t.z4;
      address_in   = 8'h26;  // byte offset $4C
      data_in      = 16'hFFFF;
      hwr          = 1'b1;
      lwr          = 1'b1;
      sel          = 1'b1;
      clk7_en      = 1'b1;
      e.name = $sformatf("v%0d_rst%0d", i, c);
      e.dev = 3'b111; e.cfg = 4'h0; e.shut = 4'h0; e.done = 1'b0; e.hit = 4'h0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      compare_next();
    end
  endtask

  task automatic apply(input vec_t t, input int i);
    exp_t e;
    if (t.rst) reset_phase(t, i);
    @(negedge clk);
    reset = 1'b0;
    drive(t);
    e.name = $sformatf("v%0d", i);
    e.dev = t.e_dev; e.cfg = t.e_cfg; e.shut = t.e_shut;
    e.done = t.e_done; e.hit = t.e_hit;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare_next();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; clk7_en = 1'b0; address_in = '0; data_in = '0;
    hwr = 1'b0; lwr = 1'b0; sel = 1'b0; board_enable = '0; zii_size = '0;
    z3b_4m = 1'b0; cpu_addr = '0;

    // ZII 8 MB + ZIII A; the first vector is a shut-up write during INIT.
    add(1, 4'b0011, 2'b11, 0, 9'h04C, 16'hFFFF, 1, 0, 1, 1, 16'h0000, 3'd0, 4'h0, 4'h0, 0, 4'h0);
    add(0, 4'b0011, 2'b11, 0, 9'h04A, 16'hA000, 1, 0, 1, 1, 16'h0000, 3'd0, 4'h0, 4'h0, 0, 4'h0);
    add(0, 4'b0011, 2'b11, 0, 9'h048, 16'h2000, 1, 0, 1, 1, 16'h0000, 3'd1, 4'h1, 4'h0, 0, 4'h0);
    idle(4'b0011, 2'b11, 0, 16'h0020, 3'd1, 4'h1, 4'h0, 0, 4'h1);
    add(0, 4'b0011, 2'b11, 0, 9'h044, 16'h4000, 1, 1, 1, 1, 16'h0000, 3'd7, 4'h3, 4'h0, 1, 4'h1);
    idle(4'b0011, 2'b11, 0, 16'h4000, 3'd7, 4'h3, 4'h0, 1, 4'h2);
    idle(4'b0011, 2'b11, 0, 16'h40FF, 3'd7, 4'h3, 4'h0, 1, 4'h2);
    idle(4'b0011, 2'b11, 0, 16'h4100, 3'd7, 4'h3, 4'h0, 1, 4'h0);
    add(0, 4'b0011, 2'b11, 0, 9'h044, 16'hFF00, 1, 0, 1, 1, 16'h4000, 3'd7, 4'h3, 4'h0, 1, 4'h2);

    // ZII 2 MB + ZIII B 2 MB: shut up ZII, then filter bad writes to ZIII B.
    add(1, 4'b0101, 2'b01, 0, 9'h000, 16'h0000, 0, 0, 0, 1, 16'h0000, 3'd0, 4'h0, 4'h0, 0, 4'h0);
    add(0, 4'b0101, 2'b01, 0, 9'h04C, 16'h0000, 1, 0, 1, 1, 16'h0000, 3'd2, 4'h0, 4'h1, 0, 4'h0);
    idle(4'b0101, 2'b01, 0, 16'h0020, 3'd2, 4'h0, 4'h1, 0, 4'h0);
    idle(4'b0101, 2'b01, 0, 16'h0000, 3'd2, 4'h0, 4'h1, 0, 4'h0);
    add(0, 4'b0101, 2'b01, 0, 9'h048, 16'h2000, 1, 0, 1, 1, 16'h0000, 3'd2, 4'h0, 4'h1, 0, 4'h0);
    add(0, 4'b0101, 2'b01, 0, 9'h04A, 16'h2000, 1, 0, 1, 1, 16'h0000, 3'd2, 4'h0, 4'h1, 0, 4'h0);
    add(0, 4'b0101, 2'b01, 0, 9'h044, 16'h1234, 1, 0, 1, 0, 16'h0000, 3'd2, 4'h0, 4'h1, 0, 4'h0);
    add(0, 4'b0101, 2'b01, 0, 9'h044, 16'h1234, 1, 0, 0, 1, 16'h0000, 3'd2, 4'h0, 4'h1, 0, 4'h0);
    add(0, 4'b0101, 2'b01, 0, 9'h044, 16'h1234, 0, 0, 1, 1, 16'h0000, 3'd2, 4'h0, 4'h1, 0, 4'h0);
    add(0, 4'b0101, 2'b01, 0, 9'h044, 16'h00C0, 0, 1, 1, 1, 16'h0000, 3'd7, 4'h4, 4'h1, 1, 4'h0);
    idle(4'b0101, 2'b01, 0, 16'h00C0, 3'd7, 4'h4, 4'h1, 1, 4'h4);
    idle(4'b0101, 2'b01, 0, 16'h00E0, 3'd7, 4'h4, 4'h1, 1, 4'h0);
    idle(4'b0101, 2'b01, 0, 16'h00D0, 3'd7, 4'h4, 4'h1, 1, 4'h4);

    // ZII 2 MB only: wrong-type write, then configure at $20.
    add(1, 4'b0001, 2'b01, 0, 9'h044, 16'h1234, 1, 1, 1, 1, 16'h0000, 3'd0, 4'h0, 4'h0, 0, 4'h0);
    add(0, 4'b0001, 2'b01, 0, 9'h044, 16'h1234, 1, 1, 1, 1, 16'h0000, 3'd0, 4'h0, 4'h0, 0, 4'h0);
    add(0, 4'b0001, 2'b01, 0, 9'h04A, 16'h0000, 1, 0, 1, 1, 16'h0000, 3'd0, 4'h0, 4'h0, 0, 4'h0);
    add(0, 4'b0001, 2'b01, 0, 9'h048, 16'h2000, 0, 1, 1, 1, 16'h0000, 3'd7, 4'h1, 4'h0, 1, 4'h0);
    idle(4'b0001, 2'b01, 0, 16'h0020, 3'd7, 4'h1, 4'h0, 1, 4'h1);
    idle(4'b0001, 2'b01, 0, 16'h0040, 3'd7, 4'h1, 4'h0, 1, 4'h0);
    idle(4'b0001, 2'b01, 0, 16'h0030, 3'd7, 4'h1, 4'h0, 1, 4'h1);
    idle(4'b0001, 2'b01, 0, 16'h0120, 3'd7, 4'h1, 4'h0, 1, 4'h0);

    // Three boards, reset after device 1 is configured.
    add(1, 4'b0111, 2'b10, 0, 9'h000, 16'h0000, 0, 0, 0, 1, 16'h0000, 3'd0, 4'h0, 4'h0, 0, 4'h0);
    add(0, 4'b0111, 2'b10, 0, 9'h04C, 16'h0000, 0, 1, 1, 1, 16'h0000, 3'd1, 4'h0, 4'h1, 0, 4'h0);
    add(0, 4'b0111, 2'b10, 0, 9'h044, 16'h1100, 1, 0, 1, 1, 16'h0000, 3'd2, 4'h2, 4'h1, 0, 4'h0);
    add(1, 4'b0111, 2'b10, 0, 9'h000, 16'h0000, 0, 0, 0, 1, 16'h1100, 3'd0, 4'h0, 4'h0, 0, 4'h0);
    idle(4'b0111, 2'b10, 0, 16'h1100, 3'd0, 4'h0, 4'h0, 0, 4'h0);

    // No boards: DONE right after INIT, writes ignored.
    add(1, 4'b0000, 2'b11, 0, 9'h000, 16'h0000, 0, 0, 0, 1, 16'h0000, 3'd7, 4'h0, 4'h0, 1, 4'h0);
    add(0, 4'b0000, 2'b11, 0, 9'h04C, 16'h0000, 1, 0, 1, 1, 16'h0000, 3'd7, 4'h0, 4'h0, 1, 4'h0);

    // ZII enabled but size 00 (absent), ETH only.
    add(1, 4'b1001, 2'b00, 0, 9'h000, 16'h0000, 0, 0, 0, 1, 16'h0000, 3'd3, 4'h0, 4'h0, 0, 4'h0);
    add(0, 4'b1001, 2'b00, 0, 9'h044, 16'hABCD, 1, 1, 1, 1, 16'h0000, 3'd7, 4'h8, 4'h0, 1, 4'h0);
    idle(4'b1001, 2'b00, 0, 16'hABCD, 3'd7, 4'h8, 4'h0, 1, 4'h8);
    idle(4'b1001, 2'b00, 0, 16'hABCC, 3'd7, 4'h8, 4'h0, 1, 4'h0);

    // ZIII B at $00C0 in 4 MB mode: $00E0 now falls inside the window.
    add(1, 4'b0100, 2'b00, 1, 9'h000, 16'h0000, 0, 0, 0, 1, 16'h0000, 3'd2, 4'h0, 4'h0, 0, 4'h0);
    add(0, 4'b0100, 2'b00, 1, 9'h044, 16'h00C0, 1, 1, 1, 1, 16'h0000, 3'd7, 4'h4, 4'h0, 1, 4'h0);
    idle(4'b0100, 2'b00, 1, 16'h00E0, 3'd7, 4'h4, 4'h0, 1, 4'h4);
    idle(4'b0100, 2'b00, 1, 16'h0100, 3'd7, 4'h4, 4'h0, 1, 4'h0);

    // ZII 8 MB at $80 for the latency sequence below.
    add(1, 4'b0001, 2'b11, 0, 9'h000, 16'h0000, 0, 0, 0, 1, 16'h0000, 3'd0, 4'h0, 4'h0, 0, 4'h0);
    add(0, 4'b0001, 2'b11, 0, 9'h04A, 16'h0000, 1, 0, 1, 1, 16'h0000, 3'd0, 4'h0, 4'h0, 0, 4'h0);
    add(0, 4'b0001, 2'b11, 0, 9'h048, 16'h8000, 1, 0, 1, 1, 16'h0000, 3'd7, 4'h1, 4'h0, 1, 4'h0);

    foreach (vecs[i]) apply(vecs[i], i);

    // Decode latency, with clk7_en low: the hit must not appear before the
    // next clk edge, must appear right after it, and must drop the same way.
    @(negedge clk);
    clk7_en  = 1'b0;
    sel      = 1'b0;
    hwr      = 1'b0;
    lwr      = 1'b0;
    cpu_addr = 16'h0080;
    #3;
    check("lat_before_edge", 16'(board_hit), 16'h0000);
    @(posedge clk);
    #1;
    check("lat_after_edge", 16'(board_hit), 16'h0001);
    @(negedge clk);
    cpu_addr = 16'h0000;
    #3;
    check("lat_hold", 16'(board_hit), 16'h0001);
    @(posedge clk);
    #1;
    check("lat_drop", 16'(board_hit), 16'h0000);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
